// File: rtl/alu_req_sched_if.sv
// alu_req_sched_if: request, ALU and response signals between requesters, scheduler and ALU
interface alu_req_sched_if #(parameter int NREQ = 4);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ*4-1:0] req_cmd;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_cmd;
  logic alu_enable;
  logic [15:0] alu_y;
  logic rsp_valid;
  logic rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [15:0] rsp_data;
  logic rsp_err;
  modport slave (
    input req_valid, req_a, req_b, req_cmd, alu_y, rsp_ready,
    output req_ready, alu_a, alu_b, alu_cmd, alu_enable, rsp_valid, rsp_id, rsp_data, rsp_err
  );
  modport master (
    output req_valid, req_a, req_b, req_cmd, alu_y, rsp_ready,
    input req_ready, alu_a, alu_b, alu_cmd, alu_enable, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_req_sched.sv
// alu_req_sched: round-robin scheduler sharing one combinational ALU among NREQ requesters
module alu_req_sched #(
  parameter int NREQ = 4,
  parameter int MULDIV_CYCLES = 3
) (
  input logic clk,
  input logic rst_n,
  alu_req_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW = MULDIV_CYCLES > 1 ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [3:0] MUL = 4'b0100;
  localparam logic [3:0] DIV = 4'b0101;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] win;
  logic [IDW-1:0] op_id;
  logic [CW-1:0] cnt;
  logic found;
  logic [3:0] win_cmd;
  logic div0;
  assign win_cmd = bus.req_cmd[4*win +: 4];
  assign div0 = bus.alu_cmd == DIV && bus.alu_b == 8'd0;
  assign bus.req_ready = (state == IDLE && found) ? NREQ'(1) << win : '0;
  // first valid requester after the last grant, wrapping around
  always_comb begin
    win = last_grant;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req_valid[(int'(last_grant) + k) % NREQ]) begin
        win = IDW'((int'(last_grant) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
  // accept one op, hold it on the ALU for its execute window, then present the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      op_id <= '0;
      cnt <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_cmd <= '0;
      bus.alu_enable <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          bus.alu_a <= bus.req_a[8*win +: 8];
          bus.alu_b <= bus.req_b[8*win +: 8];
          bus.alu_cmd <= win_cmd;
          bus.alu_enable <= 1'b1;
          op_id <= win;
          last_grant <= win;
          cnt <= (win_cmd == MUL || win_cmd == DIV) ? CW'(MULDIV_CYCLES - 1) : '0;
          state <= EXEC;
        end
        EXEC: if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          bus.alu_enable <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_id <= op_id;
          bus.rsp_err <= div0;
          bus.rsp_data <= div0 ? 16'h0000 : bus.alu_y;
          state <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
